// File: rtl/priority_encode8.sv
// priority_encode8 -- registered priority encoder.
//
// Reports the highest-numbered asserted request bit of `in` (bit WIDTH-1 has
// top priority) as a binary index, a one-hot grant, and a zero flag. Results
// are registered, with one cycle of latency.
//
// Ports:
//   clk    system clock; all state changes on its rising edge
//   rst_n  synchronous active-low reset
//   en     sample enable; `in` is encoded and outputs update on the next edge
//   in     request vector [WIDTH-1:0]
//   code   index of the highest set bit of the sampled `in`
//   grant  one-hot of the highest set bit; zero when the sampled `in` was zero
//   z      high when the sampled `in` was all zeros
//   valid  high for the cycle after each edge that sampled en=1
//
// WIDTH must be a power of two and at least 2. CODE_W is derived from WIDTH.

// Per-request lane. A request wins only when no higher-priority request is
// asserted.
module priority_encode8_lane (
  input  logic req,
  input  logic above,
  output logic gnt
);
  assign gnt = req & ~above;
endmodule

module priority_encode8 #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           in,
  output logic [$clog2(WIDTH)-1:0]   code,
  output logic [WIDTH-1:0]           grant,
  output logic                       z,
  output logic                       valid
);
  localparam int CODE_W = $clog2(WIDTH);

  logic [WIDTH-1:0]  above;
  logic [WIDTH-1:0]  grant_c;
  logic [CODE_W-1:0] code_c;
  logic              z_c;

  // above[i] is the OR of every request above bit i. Each term is built from
  // a direct slice of `in` instead of a ripple chain, so no bit of `above`
  // depends on another bit of the same vector.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      if (i == WIDTH - 1) begin : g_top
        assign above[i] = 1'b0;
      end else begin : g_mid
        assign above[i] = |in[WIDTH-1:i+1];
      end

      priority_encode8_lane u_lane (
        .req   (in[i]),
        .above (above[i]),
        .gnt   (grant_c[i])
      );
    end
  endgenerate

  // grant_c is zero or one-hot, so OR-ing the indices of the set bits gives
  // the binary index of the winner. With no winner the result is 0.
  always_comb begin
    code_c = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (grant_c[k]) code_c = code_c | CODE_W'(k);
    end
  end

  assign z_c = ~|in;

  // Result registers. Reset takes priority over en. With en low, the last
  // result is held and valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code  <= '0;
      grant <= '0;
      z     <= 1'b1;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        code  <= code_c;
        grant <= grant_c;
        z     <= z_c;
      end
    end
  end
endmodule

// File: tb/tb_priority_encode8.sv
module tb_priority_encode8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] in;
  logic [2:0] code;
  logic [7:0] grant;
  logic       z;
  logic       valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] in;
    logic [2:0] code;
    logic [7:0] grant;
    logic       z;
    logic       valid;
  } vec_t;

  typedef struct {
    logic [2:0] code;
    logic [7:0] grant;
    logic       z;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  // Model of the held result, used to predict the random stream.
  logic [2:0] m_code  = 3'd0;
  logic [7:0] m_grant = 8'h00;
  logic       m_z     = 1'b1;

  priority_encode8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in),
    .code  (code),
    .grant (grant),
    .z     (z),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus and queue its expected result. The result is
  // compared after the following rising edge.
  task automatic step(input logic r, input logic e, input logic [7:0] d, input exp_t x);
    exp_t got;
    @(negedge clk);
    rst_n = r;
    en    = e;
    in    = d;
    sb.push_back(x);
    m_code  = x.code;
    m_grant = x.grant;
    m_z     = x.z;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("code",  {5'd0, code},  {5'd0, got.code});
    chk("grant", grant,         got.grant);
    chk("z",     {7'd0, z},     {7'd0, got.z});
    chk("valid", {7'd0, valid}, {7'd0, got.valid});
  endtask

  // Predict the next result from the model state.
  function automatic exp_t predict(input logic r, input logic e, input logic [7:0] d);
    exp_t x;
    x = '{code: m_code, grant: m_grant, z: m_z, valid: 1'b0};
    if (!r) begin
      x = '{code: 3'd0, grant: 8'h00, z: 1'b1, valid: 1'b0};
    end else if (e) begin
      x = '{code: 3'd0, grant: 8'h00, z: 1'b1, valid: 1'b1};
      for (int b = 7; b >= 0; b--) begin
        if (d[b]) begin
          x.code  = 3'(b);
          x.grant = 8'h01 << b;
          x.z     = 1'b0;
          break;
        end
      end
    end
    return x;
  endfunction

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    in    = 8'hFF;

    //            rst en  in     code  grant  z  valid
    tbl.push_back('{0, 1, 8'hFF, 3'd0, 8'h00, 1, 0});
    tbl.push_back('{0, 1, 8'hFF, 3'd0, 8'h00, 1, 0});
    tbl.push_back('{1, 0, 8'hFF, 3'd0, 8'h00, 1, 0});
    tbl.push_back('{1, 1, 8'h01, 3'd0, 8'h01, 0, 1});
    tbl.push_back('{1, 1, 8'h02, 3'd1, 8'h02, 0, 1});
    tbl.push_back('{1, 1, 8'h04, 3'd2, 8'h04, 0, 1});
    tbl.push_back('{1, 1, 8'h08, 3'd3, 8'h08, 0, 1});
    tbl.push_back('{1, 1, 8'h10, 3'd4, 8'h10, 0, 1});
    tbl.push_back('{1, 1, 8'h20, 3'd5, 8'h20, 0, 1});
    tbl.push_back('{1, 1, 8'h40, 3'd6, 8'h40, 0, 1});
    tbl.push_back('{1, 1, 8'h80, 3'd7, 8'h80, 0, 1});
    tbl.push_back('{1, 1, 8'h2C, 3'd5, 8'h20, 0, 1});
    tbl.push_back('{1, 1, 8'h00, 3'd0, 8'h00, 1, 1});
    tbl.push_back('{1, 1, 8'h03, 3'd1, 8'h02, 0, 1});
    // enable hold
    tbl.push_back('{1, 1, 8'h10, 3'd4, 8'h10, 0, 1});
    tbl.push_back('{1, 0, 8'h81, 3'd4, 8'h10, 0, 0});
    tbl.push_back('{1, 0, 8'h81, 3'd4, 8'h10, 0, 0});
    tbl.push_back('{1, 0, 8'h81, 3'd4, 8'h10, 0, 0});
    tbl.push_back('{1, 1, 8'h81, 3'd7, 8'h80, 0, 1});
    // reset mid-stream, then recovery
    tbl.push_back('{1, 1, 8'hC0, 3'd7, 8'h80, 0, 1});
    tbl.push_back('{1, 1, 8'hC0, 3'd7, 8'h80, 0, 1});
    tbl.push_back('{0, 1, 8'hC0, 3'd0, 8'h00, 1, 0});
    tbl.push_back('{1, 1, 8'hC0, 3'd7, 8'h80, 0, 1});
    // hold of a zero result, then reset with en low
    tbl.push_back('{1, 1, 8'h00, 3'd0, 8'h00, 1, 1});
    tbl.push_back('{1, 0, 8'h40, 3'd0, 8'h00, 1, 0});
    tbl.push_back('{1, 1, 8'h7F, 3'd6, 8'h40, 0, 1});
    tbl.push_back('{0, 0, 8'h7F, 3'd0, 8'h00, 1, 0});

    foreach (tbl[n]) begin
      step(tbl[n].rst_n, tbl[n].en, tbl[n].in,
           '{code: tbl[n].code, grant: tbl[n].grant, z: tbl[n].z, valid: tbl[n].valid});
    end

    // Top-priority sweep: every value with bit 7 set encodes to 7 / 0x80.
    for (int v = 128; v < 256; v++) begin
      step(1'b1, 1'b1, 8'(v), '{code: 3'd7, grant: 8'h80, z: 1'b0, valid: 1'b1});
    end

    // Random stream with occasional idle cycles and resets.
    for (int n = 0; n < 300; n++) begin
      logic       r;
      logic       e;
      logic [7:0] d;
      r = ($urandom_range(0, 19) != 0);
      e = ($urandom_range(0, 3) != 0);
      d = 8'($urandom) >> $urandom_range(0, 7);
      step(r, e, d, predict(r, e, d));
    end

    chk("scoreboard_empty", 8'(sb.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the run in case stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/priority_encode8.md
Name: priority_encode8

Overview:
- Registered 8-input priority encoder: reports the index of the highest-numbered asserted input bit, a one-hot grant of that bit, and a zero flag when no bit is set.
- Bit 7 has highest priority; bit 0 has lowest.
- Used as a request arbiter/encoder stage; outputs are registered on the single system clock.

Parameters:
- WIDTH, 8, number of request inputs; must be a power of two and at least 2.
- CODE_W, log2(WIDTH) = 3, width of code output; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- en  input  1  sample enable; when high, in is encoded and outputs update next edge.
- in  input  WIDTH  request vector; bit i set = request i active.
- code  output  CODE_W  index of highest set bit of in (registered).
- grant  output  WIDTH  one-hot vector with only the highest set bit of in (registered); all zeros when in==0.
- z  output  1  zero flag: 1 when sampled in was all zeros, else 0 (registered).
- valid  output  1  high for one cycle after each edge where en was sampled high.

Behaviour:
- Reset (rst_n low at a rising edge): code=0, grant=0, z=1, valid=0. Reset overrides en. No asynchronous effect: outputs change only on clk edges.
- Latency: 1 cycle. If en=1 at edge N, code/grant/z reflect in sampled at edge N, visible after edge N; valid=1 for the cycle following edge N.
- en=0 at an edge: code, grant, z hold their previous values; valid=0.
- Encoding, with k = largest i such that in[i]=1:
  - code=k, grant=(1<<k), z=0.
  - All lower bits are don't-care. Example: any in with bit 7 set (128..255) gives code=3'b111, grant=8'h80.
- in==0: code=0, grant=0, z=1. code=0 is ambiguous with in=8'h01; z disambiguates.
- Invariants after every update:
  - grant is zero or exactly one-hot.
  - z==1 iff grant==0.
  - When z==0, grant==(1<<code).
- Continuous en=1: a new result every cycle; back-to-back changes of in produce back-to-back results with no bubbles.
- Reset asserted mid-stream: the next edge forces reset values regardless of en/in. The first sample is taken on the first edge with rst_n=1 and en=1.
- No X propagation from unused inputs: in must be fully defined when en=1. The encoder logic is purely combinational from in into the registers.

Test Plan:
- Reset: hold rst_n=0 two cycles with en=1, in=8'hFF -> code=000, grant=00, z=1, valid=0.
- Top-priority sweep: en=1, in=128..255 one per cycle -> each following cycle code=111, grant=80, z=0, valid=1.
- Single-bit walk: in=01,02,04,...,80 -> code=000,001,...,111; grant equals in; z=0.
- Mixed and zero: in=8'b0010_1100 -> code=101, grant=20, z=0. Then in=00 -> code=000, grant=00, z=1.
- Enable hold: after in=8'h10 (code=100), drive en=0 with in=8'h81 for 3 cycles -> code stays 100, grant=10, valid=0. Re-assert en -> code=111.
- Reset mid-operation: while streaming in=8'hC0 with en=1, pulse rst_n=0 one cycle -> outputs return to code=0, grant=0, z=1, valid=0. Next enabled edge gives code=111.
